// File: rtl/relay_alu_pkg.sv
// Shared types and constants for the relay ALU result stage:
// function codes, default data width and result-stage FSM states.
package relay_alu_pkg;

   localparam int unsigned ALU_WIDTH = 8;

   typedef enum logic [2:0] {
      FN_ADD  = 3'b000,
      FN_INC  = 3'b001,
      FN_AND  = 3'b010,
      FN_OR   = 3'b011,
      FN_XOR  = 3'b100,
      FN_NOT  = 3'b101,
      FN_SHL  = 3'b110,
      FN_RSVD = 3'b111
   } alu_func_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LATCH,
      ST_DONE
   } alu_stage_state_e;

endpackage

// File: rtl/relay_alu_result_stage_if.sv
// Sequencer / gate-bank / adder bundle feeding the ALU result stage.
// Optional macro RELAY_PARITY_FLAG_EN adds the p_flag signal.
interface relay_alu_result_stage_if #(
   parameter int unsigned WIDTH = relay_alu_pkg::ALU_WIDTH
);
   logic             start;
   logic [2:0]       func;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] sum_in;
   logic             carry_in;
   logic [WIDTH-1:0] not_in;
   logic [WIDTH-1:0] or_in;
   logic [WIDTH-1:0] and_in;
   logic [WIDTH-1:0] xor_in;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             z_flag;
   logic             s_flag;
   logic             cy_flag;
`ifdef RELAY_PARITY_FLAG_EN
   logic             p_flag;
`endif

   // Sequencer and upstream datapath side
   modport master (
      output start, func, b_in, sum_in, carry_in, not_in, or_in, and_in, xor_in,
`ifdef RELAY_PARITY_FLAG_EN
      input  p_flag,
`endif
      input  result, busy, done, z_flag, s_flag, cy_flag
   );

   // Result stage side
   modport slave (
      input  start, func, b_in, sum_in, carry_in, not_in, or_in, and_in, xor_in,
`ifdef RELAY_PARITY_FLAG_EN
      output p_flag,
`endif
      output result, busy, done, z_flag, s_flag, cy_flag
   );
endinterface

// File: rtl/relay_alu_result_mux.sv
// Combinational selection of the next ALU result from the captured
// function code, plus whether this function updates the carry flag.
module relay_alu_result_mux
   import relay_alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  alu_func_e        i_func_q,
   input  logic [WIDTH-1:0] i_b_in,
   input  logic [WIDTH-1:0] i_sum_in,
   input  logic [WIDTH-1:0] i_not_in,
   input  logic [WIDTH-1:0] i_or_in,
   input  logic [WIDTH-1:0] i_and_in,
   input  logic [WIDTH-1:0] i_xor_in,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cy_upd
);

   // Pick the function result; only the adder functions touch carry
   always_comb begin
      o_result = '0;
      o_cy_upd = 1'b0;
      case (i_func_q)
         FN_ADD,
         FN_INC:  begin
            o_result = i_sum_in;
            o_cy_upd = 1'b1;
         end
         FN_AND:  o_result = i_and_in;
         FN_OR:   o_result = i_or_in;
         FN_XOR:  o_result = i_xor_in;
         FN_NOT:  o_result = i_not_in;
         FN_SHL:  o_result = {i_b_in[WIDTH-2:0], i_b_in[WIDTH-1]};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/relay_alu_result_stage.sv
// ALU result stage: waits SETTLE_CYCLES for the relay logic to settle,
// latches the selected result and Z/S/Cy flags, then pulses done.
// Optional macro RELAY_PARITY_FLAG_EN adds an odd-parity flag (p_flag).
module relay_alu_result_stage
   import relay_alu_pkg::*;
#(
   parameter int unsigned WIDTH         = ALU_WIDTH,
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic                      Clock,
   input  logic                      Clear,
   relay_alu_result_stage_if.slave   bus
);

   localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   alu_stage_state_e r_state;
   alu_stage_state_e w_state_nxt;
   alu_func_e        r_func_q;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_z;
   logic             r_s;
   logic             r_cy;
   logic [WIDTH-1:0] w_next_result;
   logic             w_cy_upd;
   logic             w_busy;
   logic             w_done;
`ifdef RELAY_PARITY_FLAG_EN
   logic             r_p;
`endif

   relay_alu_result_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .i_func_q (r_func_q),
      .i_b_in   (bus.b_in),
      .i_sum_in (bus.sum_in),
      .i_not_in (bus.not_in),
      .i_or_in  (bus.or_in),
      .i_and_in (bus.and_in),
      .i_xor_in (bus.xor_in),
      .o_result (w_next_result),
      .o_cy_upd (w_cy_upd)
   );

   // State register
   always_ff @(posedge Clock) begin
      if (Clear) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; zero settle time skips straight to LATCH
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (bus.start) w_state_nxt = (SETTLE_CYCLES == 0) ? ST_LATCH : ST_SETTLE;
         ST_SETTLE: if (r_cnt == CW'(1)) w_state_nxt = ST_LATCH;
         ST_LATCH:  w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      w_busy = (r_state != ST_IDLE);
      w_done = (r_state == ST_DONE);
   end

   // Capture the function code on an accepted start and run the settle counter
   always_ff @(posedge Clock) begin
      if (Clear) begin
         r_func_q <= FN_ADD;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) begin
               r_func_q <= alu_func_e'(bus.func);
               r_cnt    <= CW'(SETTLE_CYCLES);
            end
            ST_SETTLE: r_cnt <= r_cnt - CW'(1);
            default: ;
         endcase
      end
   end

   // Result register and flags, written only at the end of LATCH
   always_ff @(posedge Clock) begin
      if (Clear) begin
         r_result <= '0;
         r_z      <= 1'b1;
         r_s      <= 1'b0;
         r_cy     <= 1'b0;
`ifdef RELAY_PARITY_FLAG_EN
         r_p      <= 1'b0;
`endif
      end else if (r_state == ST_LATCH) begin
         r_result <= w_next_result;
         r_z      <= (w_next_result == '0);
         r_s      <= w_next_result[WIDTH-1];
         if (w_cy_upd) r_cy <= bus.carry_in;
`ifdef RELAY_PARITY_FLAG_EN
         r_p      <= ^w_next_result;
`endif
      end
   end

   assign bus.result  = r_result;
   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
   assign bus.z_flag  = r_z;
   assign bus.s_flag  = r_s;
   assign bus.cy_flag = r_cy;
`ifdef RELAY_PARITY_FLAG_EN
   assign bus.p_flag  = r_p;
`endif

endmodule

// File: doc/relay_alu_result_stage.md
Name: relay_alu_result_stage

Overview:
- Downstream consumer of the 8-bit bank of universal gate blocks (bitwise NOT/OR/AND/XOR of B and C) and of the ripple adder.
- Selects one function result by 3-bit function code after a modelled relay-settle delay.
- Latches the result into the ALU output register and updates the Z/S/Cy condition flags.
- Completes a start/done handshake with the sequencer.

Parameters:
- WIDTH, 8, data path width in bits.
- SETTLE_CYCLES, 3, clock cycles waited after start before sampling the inputs; 0 is legal.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin an ALU operation; ignored unless idle.
- func  in  3  function code, sampled on an accepted start.
  - 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 reserved.
- b_in  in  WIDTH  B register value; used by SHL only.
- sum_in  in  WIDTH  adder sum; upstream forces carry-in for INC.
- carry_in  in  1  adder carry-out.
- not_in, or_in, and_in, xor_in  in  WIDTH each  gate-bank outputs.
- result  out  WIDTH  latched ALU result.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when result and flags are updated.
- z_flag, s_flag, cy_flag  out  1 each  zero, sign, carry flags.

Behaviour:
- Reset: Clear high at a rising edge returns to IDLE, regardless of state.
  - result=0, busy=0, done=0, z_flag=1 (reflects result 0), s_flag=0, cy_flag=0.
  - Settle counter cleared. Any operation in flight is abandoned; no done pulse.
- States: IDLE, SETTLE, LATCH, DONE.
- IDLE:
  - start=1 → capture func into func_q, load counter with SETTLE_CYCLES, set busy=1.
  - Next state is SETTLE, or LATCH if SETTLE_CYCLES==0.
- SETTLE: counter decrements each cycle; at counter==1 → LATCH.
- LATCH: data inputs are sampled only in this cycle; result register and flags are written at the end of it.
  - busy stays 1.
  - Next state is DONE.
- DONE: done=1 for exactly this cycle; busy falls to 0 at the end of it. Next state is IDLE.
- Latency: an accepted start at cycle N gives done high at cycle N+SETTLE_CYCLES+2.
- start while busy: ignored, not queued.
- start during DONE: ignored.
- func changes after acceptance: no effect; func_q is used.
- Result selection:
  - ADD and INC → sum_in.
  - AND/OR/XOR/NOT → the matching gate-bank input.
  - SHL → rotate left of b_in: {b_in[WIDTH-2:0], b_in[WIDTH-1]}.
  - 111 → all zeros.
- Flags, written in LATCH:
  - z_flag = (new result == 0).
  - s_flag = new result[WIDTH-1].
  - cy_flag = carry_in for ADD/INC only; held for all other codes, including SHL and 111.
- result and flags hold their values between operations.

Optional Feature:
- RELAY_PARITY_FLAG_EN defined:
  - Adds output p_flag (1 bit) = XOR-reduction of the new result (1 = odd parity), written in LATCH.
  - Reset value 0.
- Undefined: the p_flag port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package relay_alu_pkg holds:
  - alu_func_e enum (the 8 codes above);
  - the ALU_WIDTH=8 constant;
  - the state enum alu_stage_state_e.
- Sub-module relay_alu_result_mux (combinational): func_q plus the data inputs → next result and carry-update enable.
- The top module holds the FSM, counter, registers and flags.

Test Plan:
- Clear held 2 cycles then released → result=00, z=1, s=0, cy=0, busy=0, done=0.
- ADD, SETTLE_CYCLES=3, sum_in=8'h00, carry_in=1 → done exactly 5 cycles after start; result=00, z=1, s=0, cy=1.
- AND with and_in=8'h80 after the previous test → result=80, z=0, s=1, cy stays 1; func changed to OR mid-SETTLE has no effect.
- SHL, b_in=8'hA5 → result=4B, cy unchanged; a start pulse during SETTLE is ignored, with a single done and busy continuous.
- XOR in flight, Clear asserted in SETTLE → next cycle IDLE, result=00, flags at reset values, no done pulse.
- SETTLE_CYCLES=0 and code 111 → done 2 cycles after start, result=00, z=1.
  - With RELAY_PARITY_FLAG_EN: NOT with not_in=8'h07 → p_flag=1.
